// File: rtl/if_id_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_buffer                                                         |
// | IF/ID pipeline register with hazard stall and branch flush (bubble). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_id_buffer #(
  parameter int                 INSTR_WIDTH = 16,
  parameter int                 PC_WIDTH    = 16,
  parameter logic [INSTR_WIDTH-1:0] NOP_VALUE = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic [PC_WIDTH-1:0]    updatedPC,
  input  logic                   IFFlush,
  input  logic                   IFIDWrite,
  output logic [INSTR_WIDTH-1:0] instructionOut,
  output logic [PC_WIDTH-1:0]    updatedPCOut
);

  logic [INSTR_WIDTH-1:0] instr_d, instr_q;
  logic [PC_WIDTH-1:0]    pc_d,    pc_q;

  // Flush outranks the write enable so a taken branch squashes even a stalled slot.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (IFFlush) begin
      instr_d = NOP_VALUE;
      pc_d    = '0;
    end else if (IFIDWrite) begin
      instr_d = instruction;
      pc_d    = updatedPC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP_VALUE;
      pc_q    <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instructionOut = instr_q;
  assign updatedPCOut   = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_id_buffer                                                      |
// | Self-checking bench for the IF/ID pipeline register.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_if_id_buffer;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IFFlush;
  logic        IFIDWrite;
  logic [15:0] instruction;
  logic [15:0] updatedPC;
  logic [15:0] instructionOut;
  logic [15:0] updatedPCOut;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_id_buffer #(
    .INSTR_WIDTH(16),
    .PC_WIDTH   (16),
    .NOP_VALUE  (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .updatedPC     (updatedPC),
    .IFFlush       (IFFlush),
    .IFIDWrite     (IFIDWrite),
    .instructionOut(instructionOut),
    .updatedPCOut  (updatedPCOut)
  );

  // Reference: the pipeline slot as a {instr, pc} pair chosen by the edge's priority rules.
  logic [31:0] m_slot;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] slot_after_edge(input logic [31:0] cur, input logic r_n,
                                                  input logic fl, input logic we,
                                                  input logic [15:0] i, input logic [15:0] p);
    if (!r_n || fl) return {NOP, 16'h0000};
    if (we)         return {i, p};
    return cur;
  endfunction

  always @(posedge clk) begin
    m_slot  = slot_after_edge(m_slot, rst_n, IFFlush, IFIDWrite, instruction, updatedPC);
    if (!rst_n) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({instructionOut, updatedPCOut} !== m_slot) begin
        failures++;
        $display("FAIL model t=%0t: got %h/%h expected %h/%h", $time,
                 instructionOut, updatedPCOut, m_slot[31:16], m_slot[15:0]);
      end
    end
  end

  task automatic step(input logic r_n, input logic fl, input logic we,
                      input logic [15:0] i, input logic [15:0] p);
    rst_n = r_n; IFFlush = fl; IFIDWrite = we; instruction = i; updatedPC = p;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [15:0] ei, input logic [15:0] ep);
    checks++;
    if (instructionOut !== ei || updatedPCOut !== ep) begin
      failures++;
      $display("FAIL %s: got %h/%h expected %h/%h", name, instructionOut, updatedPCOut, ei, ep);
    end
  endtask

  initial begin
    rst_n = 1'b0; IFFlush = 1'b0; IFIDWrite = 1'b1;
    instruction = 16'hFFFF; updatedPC = 16'h0001;

    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0001); lit("reset",        16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0001); lit("reset_release",16'hFFFF, 16'h0001);

    step(1'b1, 1'b0, 1'b1, 16'h0000, 16'hA0A1); lit("capture",      16'h0000, 16'hA0A1);
    instruction = 16'h5555; updatedPC = 16'h5555;
    #2;                                         lit("midcycle_hold",16'h0000, 16'hA0A1);

    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 16'h3432, 16'hBBBB); lit("stall",      16'h0000, 16'hA0A1);
    end

    step(1'b1, 1'b1, 1'b1, 16'h3432, 16'hBBBB); lit("flush_over_wr",16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h3432, 16'hBBBB); lit("after_flush",  16'h3432, 16'hBBBB);

    step(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0002); lit("load_1234",    16'h1234, 16'h0002);
    step(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0002); lit("flush_stall",  16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999); lit("hold_bubble",  16'h0000, 16'h0000);

    step(1'b1, 1'b0, 1'b1, 16'h7777, 16'h0042); lit("load_7777",    16'h7777, 16'h0042);
    rst_n = 1'b0;
    #2;                                         lit("rst_not_async",16'h7777, 16'h0042);
    step(1'b0, 1'b1, 1'b1, 16'hABCD, 16'h0010); lit("rst_priority", 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hABCD, 16'h0010); lit("rst_resume",   16'hABCD, 16'h0010);

    // Mixed traffic, checked by the reference on every cycle.
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
           16'($urandom), 16'($urandom));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
